gf_horner_eval: RTL

GF_HORNER_EVAL -- requirements
Module: gf_horner_eval

---
 rtl/gf_horner_eval.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/gf_horner_eval.sv
// Evaluates a GF(2^8) polynomial at x by Horner's rule, one coefficient per accepted beat.
// Latency: result valid 1 cycle after the final coefficient is accepted.
// Backpressure: coef_ready_o only in ACCUM; result held in DONE until res_ready_i.
//
// Field: GF(2^8) generated by x^8 + x^4 + x^3 + x^2 + 1 (0x11D), alpha = 0x02.
//
// Ports (gf_horner_eval):
//   clk_i, rst_i                       clock, synchronous active-high reset
//   start_i, x_i                       launch an evaluation at point x_i
//   coef_valid_i, coef_i, coef_last_i  coefficient stream, highest degree first
//   coef_ready_o                       coefficient accepted this cycle when valid
//   res_valid_o, res_o, err_o          result P(x), overflow flag (no last seen)
//   res_ready_i                        consumer takes the result
//   busy_o                             evaluation in progress or result pending

// Combinational GF(2^8) multiplier built from log/antilog tables.
// Latency: zero (purely combinational).
// Backpressure: none; a zero operand short-circuits to a zero product.
//
// Ports (gf_mul_lut):
//   a, b   multiplicands
//   p      product a*b in GF(2^8)
module gf_mul_lut (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);

   // Multiply by alpha with reduction modulo 0x11D.
   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
   endfunction

   // alpha^n, evaluated at elaboration to fill the antilog table.
   function automatic logic [7:0] gf_exp(input int n);
      logic [7:0] e;
      e = 8'h01;
      for (int k = 0; k < n; k++) begin
         e = xtime(e);
      end
      return e;
   endfunction

   // Discrete log of v; v = 0 has no log and maps to 0 (never used).
   function automatic logic [7:0] gf_log(input logic [7:0] v);
      logic [7:0] e;
      logic [7:0] l;
      e = 8'h01;
      l = 8'h00;
      for (int k = 0; k < 255; k++) begin
         if (e == v) begin
            l = 8'(k);
         end
         e = xtime(e);
      end
      return l;
   endfunction

   logic [7:0] exp_tbl [0:255];
   logic [7:0] log_tbl [0:255];

   // Entry 255 wraps to alpha^0 so an 8-bit index never leaves the table.
   for (genvar i = 0; i < 256; i++) begin : g_tbl
      assign exp_tbl[i] = gf_exp(i);
      assign log_tbl[i] = gf_log(8'(i));
   end

   logic [8:0] log_sum;
   logic [7:0] log_idx;

   always_comb begin
      log_sum = {1'b0, log_tbl[a]} + {1'b0, log_tbl[b]};
      // Exponents live modulo 255; the sum of two logs is at most 508.
      log_idx = (log_sum >= 9'd255) ? 8'(log_sum - 9'd255) : log_sum[7:0];
      p       = ((a == 8'h00) || (b == 8'h00)) ? 8'h00 : exp_tbl[log_idx];
   end

endmodule

module gf_horner_eval #(
   parameter int MAX_COEFS = 255
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] x_i,
   input  logic       coef_valid_i,
   input  logic [7:0] coef_i,
   input  logic       coef_last_i,
   output logic       coef_ready_o,
   output logic       res_valid_o,
   output logic [7:0] res_o,
   output logic       err_o,
   input  logic       res_ready_i,
   output logic       busy_o
);

   localparam int CW = $clog2(MAX_COEFS + 1);
   // Count value before the accept that fills the coefficient budget.
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_COEFS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [7:0]    acc_q;
   logic [7:0]    x_q;
   logic [CW-1:0] cnt_q;
   logic          err_q;
   logic [7:0]    prod;

   logic accept;
   logic at_budget;
   logic finish;
   logic handshake;
   logic launch;

   gf_mul_lut u_mul (
      .a (acc_q),
      .b (x_q),
      .p (prod)
   );

   always_comb begin
      accept    = (state_q == S_ACCUM) && coef_valid_i;
      at_budget = (cnt_q == LAST_CNT);
      finish    = accept && (coef_last_i || at_budget);
      handshake = (state_q == S_DONE) && res_ready_i;
      // A new run starts from IDLE, or straight out of DONE when the result
      // is taken in the same cycle as the next start.
      launch    = start_i && ((state_q == S_IDLE) || handshake);
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (finish) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (handshake) begin
               state_d = start_i ? S_ACCUM : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode the state flop only, so no input reaches them combinationally.
   always_comb begin
      coef_ready_o = 1'b0;
      res_valid_o  = 1'b0;
      busy_o       = 1'b0;
      unique case (state_q)
         S_ACCUM: begin
            coef_ready_o = 1'b1;
            busy_o       = 1'b1;
         end
         S_DONE: begin
            res_valid_o = 1'b1;
            busy_o      = 1'b1;
         end
         default: begin
            coef_ready_o = 1'b0;
         end
      endcase
   end

   // Datapath: x latch, Horner accumulator, coefficient count, overflow flag.
   // Accepts only happen in ACCUM and launches never do, so the two are exclusive.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= 8'h00;
         x_q   <= 8'h00;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (launch) begin
         acc_q <= 8'h00;
         x_q   <= x_i;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (accept) begin
         acc_q <= prod ^ coef_i;
         cnt_q <= cnt_q + 1'b1;
         if (at_budget && !coef_last_i) begin
            err_q <= 1'b1;
         end
      end
   end

   // The accumulator is not touched in DONE, so it doubles as the held result.
   assign res_o = acc_q;
   assign err_o = err_q;

endmodule
